pipe_stage_skid_reg: RTL and testbench

- Parametrised, elastic successor to the fixed ID->EX stage register. It carries a generic control bundle and a generic data bundle between two pipeline stages using valid/ready handshakes.
- A 2-entry skid buffer gives full throughput while keeping in_ready registered, so there is no combinational ready path back through the stage.
- Supports synchronous flush for branch mispredicts. Any stage boundary of the ARM-subset core (IF/ID, ID/EX, EX/MEM) can instantiate it.

---
 rtl/pipe_pkg.sv | 56 +++++
 rtl/pipe_stage_skid_reg_if.sv | 27 ++
 rtl/pipe_stage_skid_reg.sv | 102 ++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: bundle widths, control bit map,
// and the ID/EX data-field layout.
package pipe_pkg;

    localparam int CTRL_W = 8;
    localparam int DATA_W = 160;

    localparam int CTRL_WB_EN  = 0;
    localparam int CTRL_MEM_RD = 1;
    localparam int CTRL_MEM_WR = 2;
    localparam int CTRL_BRANCH = 3;
    localparam int CTRL_S      = 4;
    localparam int CTRL_IMM    = 5;
    localparam int CTRL_CARRY  = 6;
    localparam int CTRL_SPARE  = 7;

    localparam int IDEX_PC_LSB   = 0;
    localparam int IDEX_PC_W     = 32;
    localparam int IDEX_RN_LSB   = 32;
    localparam int IDEX_RN_W     = 32;
    localparam int IDEX_RM_LSB   = 64;
    localparam int IDEX_RM_W     = 32;
    localparam int IDEX_SHOP_LSB = 96;
    localparam int IDEX_SHOP_W   = 12;
    localparam int IDEX_SIMM_LSB = 108;
    localparam int IDEX_SIMM_W   = 24;
    localparam int IDEX_DEST_LSB = 132;
    localparam int IDEX_SRC1_LSB = 136;
    localparam int IDEX_SRC2_LSB = 140;
    localparam int IDEX_REG_W    = 4;
    localparam int IDEX_USED_W   = 144;

    // Field order mirrors the offsets above: pc sits at bit 0.
    typedef struct packed {
        logic [IDEX_REG_W-1:0]  src2;
        logic [IDEX_REG_W-1:0]  src1;
        logic [IDEX_REG_W-1:0]  dest;
        logic [IDEX_SIMM_W-1:0] signed_imm;
        logic [IDEX_SHOP_W-1:0] shift_operand;
        logic [IDEX_RM_W-1:0]   val_rm;
        logic [IDEX_RN_W-1:0]   val_rn;
        logic [IDEX_PC_W-1:0]   pc;
    } idex_data_t;

    localparam logic [CTRL_W-1:0] CTRL_SIDE_FX_MASK =
        CTRL_W'((1 << CTRL_WB_EN) | (1 << CTRL_MEM_WR) | (1 << CTRL_BRANCH));

    function automatic logic [DATA_W-1:0] pack_idex(input idex_data_t d);
        return {{(DATA_W - IDEX_USED_W){1'b0}}, d};
    endfunction

    function automatic logic ctrl_side_effect(input logic [CTRL_W-1:0] c);
        return |(c & CTRL_SIDE_FX_MASK);
    endfunction

endpackage

// File: rtl/pipe_stage_skid_reg_if.sv
// Valid/ready beat carrying one control bundle and one data bundle.
// master drives the beat, slave returns ready.
interface pipe_stage_skid_reg_if #(
    parameter int CTRL_W = pipe_pkg::CTRL_W,
    parameter int DATA_W = pipe_pkg::DATA_W
);

    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (
        output valid,
        output ctrl,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  ctrl,
        input  data,
        output ready
    );

endinterface

// File: rtl/pipe_stage_skid_reg.sv
// Elastic pipeline register: main entry plus one skid entry, so the
// upstream ready is a flop output and never a combinational path.
module pipe_stage_skid_reg #(
    parameter int CTRL_W         = pipe_pkg::CTRL_W,
    parameter int DATA_W         = pipe_pkg::DATA_W,
    parameter bit ZERO_ON_BUBBLE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    pipe_stage_skid_reg_if.slave  up,
    pipe_stage_skid_reg_if.master dn,
    output logic [1:0]            occupancy
);

    import pipe_pkg::*;

    localparam int NENT = 2;
    localparam int MI   = 0;
    localparam int SI   = 1;

    logic [NENT-1:0]   w_vld;
    logic [CTRL_W-1:0] w_ctrl     [NENT];
    logic [DATA_W-1:0] w_data     [NENT];
    logic [NENT-1:0]   w_ld;
    logic [NENT-1:0]   w_vld_nxt;
    logic [CTRL_W-1:0] w_ctrl_nxt [NENT];
    logic [DATA_W-1:0] w_data_nxt [NENT];

    logic w_clr;
    logic w_in_fire;
    logic w_out_fire;
    logic w_m_free;
    logic w_mask;

    for (genvar g = 0; g < NENT; g++) begin : g_ent
        logic              r_vld;
        logic [CTRL_W-1:0] r_ctrl;
        logic [DATA_W-1:0] r_data;

        always_ff @(posedge clk) begin
            r_vld <= w_vld_nxt[g];
            if (w_ld[g]) begin
                r_ctrl <= w_ctrl_nxt[g];
                r_data <= w_data_nxt[g];
            end
        end

        assign w_vld[g]  = r_vld;
        assign w_ctrl[g] = r_ctrl;
        assign w_data[g] = r_data;
    end

    assign w_clr      = rst | flush;
    assign w_in_fire  = up.valid & ~w_vld[SI];
    assign w_out_fire = w_vld[MI] & dn.ready;
    assign w_m_free   = ~w_vld[MI] | w_out_fire;

    always_comb begin
        w_ld      = '0;
        w_vld_nxt = w_vld;
        for (int i = 0; i < NENT; i++) begin
            w_ctrl_nxt[i] = '0;
            w_data_nxt[i] = '0;
        end

        if (w_clr) begin
            // Both valid bits and payloads drop; the inbound beat is lost.
            w_ld      = '1;
            w_vld_nxt = '0;
        end else if (w_m_free) begin
            if (w_vld[SI]) begin
                w_ld[MI]       = 1'b1;
                w_vld_nxt[MI]  = 1'b1;
                w_ctrl_nxt[MI] = w_ctrl[SI];
                w_data_nxt[MI] = w_data[SI];
                w_vld_nxt[SI]  = 1'b0;
            end else if (w_in_fire) begin
                w_ld[MI]       = 1'b1;
                w_vld_nxt[MI]  = 1'b1;
                w_ctrl_nxt[MI] = up.ctrl;
                w_data_nxt[MI] = up.data;
            end else begin
                w_vld_nxt[MI]  = 1'b0;
            end
        end else if (w_in_fire) begin
            w_ld[SI]       = 1'b1;
            w_vld_nxt[SI]  = 1'b1;
            w_ctrl_nxt[SI] = up.ctrl;
            w_data_nxt[SI] = up.data;
        end
    end

    assign w_mask = ZERO_ON_BUBBLE & ~w_vld[MI];

    assign up.ready  = ~w_vld[SI];
    assign dn.valid  = w_vld[MI];
    assign dn.ctrl   = w_mask ? '0 : w_ctrl[MI];
    assign dn.data   = w_mask ? '0 : w_data[MI];
    assign occupancy = {1'b0, w_vld[MI]} + {1'b0, w_vld[SI]};

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed vector table plus a randomized queue-model run for the
// skid-buffered pipeline register.
module tb_pipe_stage_skid_reg;

    import pipe_pkg::*;

    localparam int CW = 8;
    localparam int DW = 160;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        iv;
        logic [7:0]  ci;
        logic [15:0] di;
        logic        ordy;
        logic        ov;
        logic        ir;
        logic [1:0]  occ;
        logic [7:0]  co;
        logic [15:0] dout;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [CW-1:0] ctrl_in;
    logic [DW-1:0] data_in;
    logic [1:0]    occ;
    logic [1:0]    occ0;

    int n_checks = 0;
    int n_errs   = 0;

    vec_t vt[$];

    pipe_stage_skid_reg_if #(.CTRL_W(CW), .DATA_W(DW)) up  ();
    pipe_stage_skid_reg_if #(.CTRL_W(CW), .DATA_W(DW)) dn  ();
    pipe_stage_skid_reg_if #(.CTRL_W(CW), .DATA_W(DW)) up0 ();
    pipe_stage_skid_reg_if #(.CTRL_W(CW), .DATA_W(DW)) dn0 ();

    assign up.valid  = in_valid;
    assign up.ctrl   = ctrl_in;
    assign up.data   = data_in;
    assign dn.ready  = out_ready;
    assign up0.valid = in_valid;
    assign up0.ctrl  = ctrl_in;
    assign up0.data  = data_in;
    assign dn0.ready = out_ready;

    pipe_stage_skid_reg #(
        .CTRL_W(CW), .DATA_W(DW), .ZERO_ON_BUBBLE(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .up(up), .dn(dn), .occupancy(occ)
    );

    pipe_stage_skid_reg #(
        .CTRL_W(CW), .DATA_W(DW), .ZERO_ON_BUBBLE(1'b0)
    ) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .up(up0), .dn(dn0), .occupancy(occ0)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [191:0] act,
                         input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic f, input logic iv,
                       input logic [7:0] ci, input logic [15:0] di,
                       input logic ordy, input logic ov, input logic ir,
                       input logic [1:0] oc, input logic [7:0] co,
                       input logic [15:0] dout);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.ci = ci; v.di = di;
        v.ordy = ordy; v.ov = ov; v.ir = ir; v.occ = oc;
        v.co = co; v.dout = dout;
        vt.push_back(v);
    endtask

    initial begin
        logic [15:0] q[$];
        logic        pend;
        logic [15:0] pend_d;
        logic [15:0] seq;
        logic        fo;
        logic        fi;
        logic [15:0] hd;

        // reset with a live input beat
        add(1,0,1,8'hFF,16'hAAAA,1, 0,1,0,8'h00,16'h0);
        add(1,0,1,8'hFF,16'hAAAA,1, 0,1,0,8'h00,16'h0);
        add(0,0,0,8'h00,16'h0,   1, 0,1,0,8'h00,16'h0);
        // streaming
        for (int i = 0; i < 8; i++)
            add(0,0,1,8'h01,16'(i),1, 1,1,1,8'h01,16'(i));
        add(0,0,0,8'h00,16'h0,1, 0,1,0,8'h00,16'h0);
        // stall and skid
        add(0,0,1,8'h01,16'h30,1, 1,1,1,8'h01,16'h30);
        add(0,0,1,8'h01,16'h31,1, 1,1,1,8'h01,16'h31);
        add(0,0,1,8'h01,16'h32,0, 1,0,2,8'h01,16'h31);
        add(0,0,1,8'h01,16'h33,0, 1,0,2,8'h01,16'h31);
        add(0,0,1,8'h01,16'h33,0, 1,0,2,8'h01,16'h31);
        add(0,0,1,8'h01,16'h33,1, 1,1,1,8'h01,16'h32);
        add(0,0,1,8'h01,16'h33,1, 1,1,1,8'h01,16'h33);
        add(0,0,0,8'h00,16'h0, 1, 0,1,0,8'h00,16'h0);
        // flush with both entries full
        add(0,0,1,8'h02,16'h40,0, 1,1,1,8'h02,16'h40);
        add(0,0,1,8'h02,16'h41,0, 1,0,2,8'h02,16'h40);
        add(0,1,1,8'h02,16'h42,0, 0,1,0,8'h00,16'h0);
        add(0,0,0,8'h00,16'h0, 1, 0,1,0,8'h00,16'h0);
        // stale main entry for bubble masking
        add(0,0,1,8'h07,16'h55,0, 1,1,1,8'h07,16'h55);
        add(0,0,0,8'h00,16'h0, 1, 0,1,0,8'h00,16'h0);

        foreach (vt[i]) begin
            rst       = vt[i].rst;
            flush     = vt[i].flush;
            in_valid  = vt[i].iv;
            ctrl_in   = vt[i].ci;
            data_in   = {{(DW-16){1'b0}}, vt[i].di};
            out_ready = vt[i].ordy;
            @(posedge clk);
            #1;
            check($sformatf("v%0d out_valid", i), 192'(dn.valid),
                  192'(vt[i].ov));
            check($sformatf("v%0d in_ready", i), 192'(up.ready),
                  192'(vt[i].ir));
            check($sformatf("v%0d occupancy", i), 192'(occ),
                  192'(vt[i].occ));
            check($sformatf("v%0d ctrl_out", i), 192'(dn.ctrl),
                  192'(vt[i].co));
            check($sformatf("v%0d data_out", i), 192'(dn.data),
                  192'(vt[i].dout));
        end

        check("zob0 stale ctrl", 192'(dn0.ctrl), 192'(8'h07));
        check("zob0 stale data", 192'(dn0.data), 192'(16'h55));
        check("zob0 out_valid", 192'(dn0.valid), 192'(1'b0));
        check("bubble side effect", 192'(ctrl_side_effect(dn.ctrl)),
              192'(1'b0));

        // randomized run against a 2-deep queue
        pend   = 1'b0;
        pend_d = '0;
        seq    = '0;
        for (int c = 0; c < 10000; c++) begin
            if (!pend) begin
                pend   = ($urandom_range(0, 3) != 0);
                seq    = seq + 16'd1;
                pend_d = seq;
            end
            rst       = 1'b0;
            in_valid  = pend;
            ctrl_in   = pend_d[7:0] ^ 8'h5A;
            data_in   = {{(DW-16){1'b0}}, pend_d};
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 99) < 5);

            hd = (q.size() > 0) ? q[0] : 16'h0;
            check($sformatf("rand c%0d state", c),
                  192'({dn.valid, up.ready, occ, dn.ctrl, dn.data}),
                  192'({q.size() > 0, q.size() < 2, 2'(q.size()),
                        (q.size() > 0) ? (hd[7:0] ^ 8'h5A) : 8'h00,
                        {(DW-16){1'b0}}, hd}));

            fo = (q.size() > 0) && out_ready;
            fi = pend && (q.size() < 2);
            if (flush) begin
                q.delete();
            end else begin
                if (fo) void'(q.pop_front());
                if (fi) q.push_back(pend_d);
            end
            if (fi) pend = 1'b0;
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errs);
        $finish;
    end

endmodule
